// File: rtl/pkg_core_ctrl.sv
// Shared control definitions for the core pipeline: tag width, NOP tag,
// per-stage destination control record and the default event counter width.
package pkg_core_ctrl;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    localparam logic [TAG_W-1:0] NOP_TAG = 4'd0;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rf_en;
        logic             ld_en;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_NOP = '{tag: NOP_TAG, rf_en: 1'b0, ld_en: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             at_max_s;

    assign at_max_s = (count_r == {CNT_W{1'b1}});

    // Next-count selection: advance only on an event and only below saturation
    always_comb begin
        count_nxt_s = count_r;
        if (inc && !at_max_s) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dest_tag_pipe.sv
// Carries destination tags and write-class enables from ID through EX/MEM/WB,
// replacing the ID instruction with a bubble on load-use stall or branch flush.
module dest_tag_pipe
    import pkg_core_ctrl::*;
#(
    parameter int TAG_W = pkg_core_ctrl::TAG_W,
    parameter int CNT_W = pkg_core_ctrl::CNT_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [TAG_W-1:0] RD_ID,
    input  logic             rf_en_ID,
    input  logic             ld_en_ID,
    input  logic             C_Unit_MUX,
    input  logic             FLUSH,
    output logic [TAG_W-1:0] RW_EX,
    output logic [TAG_W-1:0] RW_MEM,
    output logic [TAG_W-1:0] RW_WB,
    output logic             enable_LD_EX,
    output logic             enable_RF_EX,
    output logic             enable_RF_MEM,
    output logic             enable_RF_WB,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    stage_ctrl_t ex_r;
    stage_ctrl_t mem_r;
    stage_ctrl_t wb_r;
    stage_ctrl_t ex_nxt_s;
    logic        bubble_s;
    logic        stall_evt_s;
    logic        flush_evt_s;

    assign bubble_s = FLUSH | ~C_Unit_MUX;

    // EX input select: bubble or the ID instruction's control
    always_comb begin
        ex_nxt_s = STAGE_NOP;
        if (bubble_s) begin
            ex_nxt_s = STAGE_NOP;
        end else begin
            ex_nxt_s.tag   = RD_ID;
            ex_nxt_s.rf_en = rf_en_ID;
            ex_nxt_s.ld_en = ld_en_ID;
        end
    end

    // EX/MEM/WB stage registers; downstream stages never stall
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_r  <= STAGE_NOP;
            mem_r <= STAGE_NOP;
            wb_r  <= STAGE_NOP;
        end else begin
            ex_r  <= ex_nxt_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // Flush wins when both requests arrive together: one bubble, one count
    always_comb begin
        flush_evt_s = 1'b0;
        stall_evt_s = 1'b0;
        if (FLUSH) begin
            flush_evt_s = 1'b1;
        end else if (!C_Unit_MUX) begin
            stall_evt_s = 1'b1;
        end else begin
            flush_evt_s = 1'b0;
            stall_evt_s = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (stall_evt_s),
        .count (STALL_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RESET_N),
        .inc   (flush_evt_s),
        .count (FLUSH_CNT)
    );

    assign RW_EX         = ex_r.tag;
    assign RW_MEM        = mem_r.tag;
    assign RW_WB         = wb_r.tag;
    assign enable_LD_EX  = ex_r.ld_en;
    assign enable_RF_EX  = ex_r.rf_en;
    assign enable_RF_MEM = mem_r.rf_en;
    assign enable_RF_WB  = wb_r.rf_en;

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Randomized and directed bench for dest_tag_pipe against a history-based model.
module tb_dest_tag_pipe;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = 65535;

    logic             CLK;
    logic             RESET_N;
    logic [TAG_W-1:0] RD_ID;
    logic             rf_en_ID;
    logic             ld_en_ID;
    logic             C_Unit_MUX;
    logic             FLUSH;
    logic [TAG_W-1:0] RW_EX, RW_MEM, RW_WB;
    logic             enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

    dest_tag_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .RD_ID        (RD_ID),
        .rf_en_ID     (rf_en_ID),
        .ld_en_ID     (ld_en_ID),
        .C_Unit_MUX   (C_Unit_MUX),
        .FLUSH        (FLUSH),
        .RW_EX        (RW_EX),
        .RW_MEM       (RW_MEM),
        .RW_WB        (RW_WB),
        .enable_LD_EX (enable_LD_EX),
        .enable_RF_EX (enable_RF_EX),
        .enable_RF_MEM(enable_RF_MEM),
        .enable_RF_WB (enable_RF_WB),
        .STALL_CNT    (STALL_CNT),
        .FLUSH_CNT    (FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of what entered EX on each edge since reset, newest first.
    typedef struct { int tag; int rf; int ld; } ent_t;
    ent_t hist[$];
    int   m_stall = 0;
    int   m_flush = 0;

    function automatic ent_t at_age(input int age);
        ent_t z;
        z.tag = 0; z.rf = 0; z.ld = 0;
        if (age < hist.size()) return hist[age];
        return z;
    endfunction

    always @(negedge RESET_N) begin
        hist.delete();
        m_stall = 0;
        m_flush = 0;
    end

    always @(posedge CLK) begin
        ent_t e;
        if (RESET_N === 1'b1) begin
            if (FLUSH || !C_Unit_MUX) begin
                e.tag = 0; e.rf = 0; e.ld = 0;
            end else begin
                e.tag = int'(RD_ID); e.rf = int'(rf_en_ID); e.ld = int'(ld_en_ID);
            end
            hist.push_front(e);
            if (hist.size() > 3) void'(hist.pop_back());
            if (FLUSH) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            else if (!C_Unit_MUX) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        ent_t ex, mem, wb;
        ex  = at_age(0);
        mem = at_age(1);
        wb  = at_age(2);
        chk("m_rw_ex",  32'(RW_EX),         32'(ex.tag));
        chk("m_ld_ex",  32'(enable_LD_EX),  32'(ex.ld));
        chk("m_rf_ex",  32'(enable_RF_EX),  32'(ex.rf));
        chk("m_rw_mem", 32'(RW_MEM),        32'(mem.tag));
        chk("m_rf_mem", 32'(enable_RF_MEM), 32'(mem.rf));
        chk("m_rw_wb",  32'(RW_WB),         32'(wb.tag));
        chk("m_rf_wb",  32'(enable_RF_WB),  32'(wb.rf));
        chk("m_stall",  32'(STALL_CNT),     32'(m_stall));
        chk("m_flush",  32'(FLUSH_CNT),     32'(m_flush));
    end

    // Drive one ID cycle (called just after a falling edge) and wait for the next falling edge.
    task automatic step(input int tag, input bit rf, input bit ld, input bit mux, input bit fl);
        RD_ID      = tag[TAG_W-1:0];
        rf_en_ID   = rf;
        ld_en_ID   = ld;
        C_Unit_MUX = mux;
        FLUSH      = fl;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        int guard;
        RESET_N = 1'b0; RD_ID = '0; rf_en_ID = 1'b0; ld_en_ID = 1'b0;
        C_Unit_MUX = 1'b1; FLUSH = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_rw_ex", 32'(RW_EX), 32'd0);
        chk("rst_rf_wb", 32'(enable_RF_WB), 32'd0);
        chk("rst_stall", 32'(STALL_CNT), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK); #1;

        // Straight-line flow
        step(3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sl_ex3", 32'(RW_EX), 32'd3);
        chk("sl_rf_ex", 32'(enable_RF_EX), 32'd1);
        step(5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sl_ex5", 32'(RW_EX), 32'd5);
        chk("sl_mem3", 32'(RW_MEM), 32'd3);
        step(7, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sl_ex7", 32'(RW_EX), 32'd7);
        chk("sl_mem5", 32'(RW_MEM), 32'd5);
        chk("sl_wb3", 32'(RW_WB), 32'd3);
        chk("sl_rf_wb", 32'(enable_RF_WB), 32'd1);

        // Load-use bubble
        step(4, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lu_ex4", 32'(RW_EX), 32'd4);
        chk("lu_ld", 32'(enable_LD_EX), 32'd1);
        step(9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_bub_tag", 32'(RW_EX), 32'd0);
        chk("lu_bub_en", 32'({enable_LD_EX, enable_RF_EX}), 32'd0);
        chk("lu_stall1", 32'(STALL_CNT), 32'd1);
        step(9, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lu_ex9", 32'(RW_EX), 32'd9);
        chk("lu_mem_bub", 32'({RW_MEM, enable_RF_MEM}), 32'd0);
        step(2, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("lu_wb_bub", 32'({RW_WB, enable_RF_WB}), 32'd0);

        // Flush with simultaneous stall
        step(6, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("fs_bub", 32'({RW_EX, enable_RF_EX, enable_LD_EX}), 32'd0);
        chk("fs_flush1", 32'(FLUSH_CNT), 32'd1);
        chk("fs_stall1", 32'(STALL_CNT), 32'd1);

        // Legal load without register write
        step(12, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ldnorf", 32'({RW_EX, enable_RF_EX, enable_LD_EX}), {26'd0, 4'd12, 1'b0, 1'b1});

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0));
        end

        // Asynchronous reset mid-flow
        step(13, 1'b1, 1'b0, 1'b1, 1'b0);
        step(14, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("ar_tags", 32'({RW_EX, RW_MEM, RW_WB}), 32'd0);
        chk("ar_en", 32'({enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB}), 32'd0);
        chk("ar_cnt", {STALL_CNT, FLUSH_CNT}, 32'd0);
        @(negedge CLK);
        #2;
        RESET_N = 1'b1;
        step(11, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ar_first", 32'({RW_EX, enable_RF_EX}), {27'd0, 4'd11, 1'b1});

        // Saturation: stall continuously up to 0xFFFE, then three more
        guard = 0;
        while (m_stall < 32'hFFFE && guard < 70000) begin
            step(1, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("sat_pre", 32'(STALL_CNT), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            step(1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("sat_hold", 32'(STALL_CNT), 32'h0000_FFFF);
        end
        step(1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sat_stay", 32'(STALL_CNT), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dest_tag_pipe.md
# dest_tag_pipe

Destination-tag tracking pipeline for the 5-stage ARM core. It carries each instruction's destination register tag and write-class enables from ID through EX, MEM and WB. It inserts a bubble into EX whenever the hazard unit requests a load-use stall or a branch flush squashes the ID instruction. Its registered outputs are the RW_*/enable_* inputs of the hazard/forwarding unit, so this block is the producer side of that interface.

## Interface
Parameters:
- TAG_W, 4, register tag width (R0–R15)
- CNT_W, 16, width of the stall and flush event counters

Ports:
- CLK  in  1  core clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- RD_ID  in  TAG_W  destination tag of the instruction in ID
- rf_en_ID  in  1  ID instruction writes the register file
- ld_en_ID  in  1  ID instruction is a load
- C_Unit_MUX  in  1  from hazard unit; 0 = replace ID control with NOP
- FLUSH  in  1  branch taken in ID; squash the ID instruction
- RW_EX, RW_MEM, RW_WB  out  TAG_W each  registered destination tags per stage
- enable_LD_EX  out  1  EX-stage instruction is a load
- enable_RF_EX, enable_RF_MEM, enable_RF_WB  out  1 each  stage writes the register file
- STALL_CNT  out  CNT_W  saturating count of load-use bubbles
- FLUSH_CNT  out  CNT_W  saturating count of flush bubbles

## Operation
- Stage registers: EX {tag, rf_en, ld_en}, MEM {tag, rf_en}, WB {tag, rf_en}. All outputs come directly from flops.
- Bubble condition: B = FLUSH | ~C_Unit_MUX.
- EX update:
  - If B, EX loads tag = 0, rf_en = 0, ld_en = 0.
  - Otherwise EX loads {RD_ID, rf_en_ID, ld_en_ID}.
  - ld_en_ID=1 with rf_en_ID=0 is legal: the load flag is carried and the write enable stays 0.
- MEM ← EX and WB ← MEM every cycle, unconditionally. EX/MEM/WB never stall, so a bubble drains out after 3 cycles.
- Counters:
  - FLUSH=1: FLUSH_CNT increments.
  - FLUSH=0 and C_Unit_MUX=0: STALL_CNT increments.
  - FLUSH=1 and C_Unit_MUX=0 in the same cycle: one bubble is inserted and only FLUSH_CNT increments (flush has priority).
  - Both counters saturate at all-ones and never wrap.
- Tags of bubble stages read 0 with enable 0. Consumers must qualify tags with the enables.

## Timing
- Reset (RESET_N low, asynchronous): all tags 0, all enables 0, both counters 0. All state holds until the first rising CLK edge after RESET_N rises.
- Reset asserted mid-operation clears every stage immediately. No partial bubble or counter update survives.
- Latency:
  - ID inputs appear on the EX outputs 1 cycle after the sampling edge.
  - They appear on the MEM outputs after 2 cycles and on the WB outputs after 3.
- A load-use stall holds C_Unit_MUX=0 for one cycle. The ID instruction is re-presented the next cycle and enters EX one cycle late. This block never holds or repeats anything itself.
- No combinational path from any input to any output.

## Structure
- Shared package pkg_core_ctrl:
  - TAG_W
  - NOP tag constant (0)
  - stage control struct {tag, rf_en, ld_en}
  - CNT_W default
- One natural sub-module: sat_counter (CNT_W, inc, asynchronous active-low clear), instantiated twice.
- Stage registers live inline in dest_tag_pipe.

## Test plan
- Reset then straight-line flow:
  - Stimulus: RD_ID = 3, 5, 7 on consecutive cycles, rf_en_ID=1, C_Unit_MUX=1.
  - Response: RW_EX=3 at cycle 1, RW_MEM=3 at cycle 2, RW_WB=3 at cycle 3; tags 5 and 7 follow one cycle apart; all enables 1.
- Load-use bubble:
  - Stimulus: load with RD_ID=4, ld_en_ID=1, then C_Unit_MUX=0 for one cycle.
  - Response: enable_LD_EX=1 with RW_EX=4, then EX shows tag 0 with all enables 0; the bubble appears on MEM and WB on the following cycles; STALL_CNT=1.
- Flush with simultaneous stall:
  - Stimulus: FLUSH=1 and C_Unit_MUX=0 in the same cycle.
  - Response: a single bubble in EX; FLUSH_CNT=1; STALL_CNT unchanged.
- Saturation:
  - Stimulus: preload or force STALL_CNT to 0xFFFE, then apply 3 stall cycles.
  - Response: STALL_CNT reads 0xFFFF and stays there.
- Asynchronous reset mid-flow:
  - Stimulus: drop RESET_N between clock edges while tags are in flight.
  - Response: all outputs 0 before the next edge; first post-reset edge loads ID normally.
